channel_event_arbiter: RTL and testbench

// - Round-robin arbiter sharing the single event-FIFO write port among the NUMCHANNELS per-channel

---
 rtl/larpix_arb_pkg.sv | 20 ++
 rtl/channel_event_arbiter_rr_select.sv | 37 +++
 rtl/channel_event_arbiter.sv | 82 ++++++++
 tb/tb_channel_event_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/larpix_arb_pkg.sv
// Shared types and defaults for the LArPix channel event arbiter.
// Holds payload/id widths and the FIFO word layout.
package larpix_arb_pkg;

  localparam int DEF_NUMCHANNELS = 64;
  localparam int DEF_EVENT_W     = 36;
  localparam int DEF_CNT_W       = 16;

  function automatic int chan_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CHAN_ID_W = chan_id_w(DEF_NUMCHANNELS);

  typedef struct packed {
    logic [DEF_CHAN_ID_W-1:0] chan_id;
    logic [DEF_EVENT_W-1:0]   payload;
  } fifo_word_t;

endpackage

// File: rtl/channel_event_arbiter_rr_select.sv
// Combinational round-robin pick: rotate requests by the pointer,
// take the lowest set bit, then map back to an absolute channel index.
module rr_priority_select
  import larpix_arb_pkg::*;
#(
  parameter int N   = DEF_NUMCHANNELS,
  parameter int IDW = chan_id_w(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic           o_grant_valid,
  output logic [IDW-1:0] o_grant_idx
);

  localparam logic [IDW:0] NVAL = (IDW+1)'(N);

  logic [N-1:0]   w_rot;
  logic [IDW-1:0] w_off;
  logic [IDW:0]   w_sum;

  assign w_rot = N'({i_req, i_req} >> i_ptr);

  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDW'(i);
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};

  assign o_grant_idx = (w_sum >= NVAL) ? IDW'(w_sum - NVAL)
                                       : w_sum[IDW-1:0];

  assign o_grant_valid = |i_req;

endmodule

// File: rtl/channel_event_arbiter.sv
// Round-robin arbiter sharing one event-FIFO write port among channels.
// One register stage: grant in cycle N shows as ack/write at edge N+1.
module channel_event_arbiter
  import larpix_arb_pkg::*;
#(
  parameter int NUMCHANNELS = DEF_NUMCHANNELS,
  parameter int EVENT_W     = DEF_EVENT_W,
  parameter int CHAN_ID_W   = chan_id_w(NUMCHANNELS),
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           arb_enable,
  input  logic [NUMCHANNELS-1:0]         event_valid,
  input  logic [NUMCHANNELS*EVENT_W-1:0] event_data,
  output logic [NUMCHANNELS-1:0]         event_ack,
  input  logic                           fifo_full,
  output logic                           fifo_write,
  output logic [CHAN_ID_W+EVENT_W-1:0]   fifo_data,
  output logic                           busy,
  output logic [CNT_W-1:0]               event_count
);

  logic [NUMCHANNELS-1:0]         r_ack;
  logic                           r_write;
  logic [CHAN_ID_W+EVENT_W-1:0]   r_data;
  logic [CNT_W-1:0]               r_count;
  logic [CHAN_ID_W-1:0]           r_ptr;
  logic [NUMCHANNELS-1:0]         r_mask;

  logic [NUMCHANNELS-1:0]         w_elig;
  logic                           w_gv;
  logic [CHAN_ID_W-1:0]           w_g;
  logic                           w_grant;
  logic [CHAN_ID_W-1:0]           w_next_ptr;
  logic [NUMCHANNELS-1:0]         w_onehot;

  // Last winner sits out one cycle so it can drop valid after its ack
  assign w_elig  = event_valid & ~r_mask;
  assign w_grant = arb_enable & ~fifo_full & w_gv;

  rr_priority_select #(
    .N   (NUMCHANNELS),
    .IDW (CHAN_ID_W)
  ) u_sel (
    .i_req         (w_elig),
    .i_ptr         (r_ptr),
    .o_grant_valid (w_gv),
    .o_grant_idx   (w_g)
  );

  assign w_next_ptr = (w_g == CHAN_ID_W'(NUMCHANNELS - 1)) ? '0
                                                           : w_g + 1'b1;
  assign w_onehot   = {{(NUMCHANNELS-1){1'b0}}, 1'b1} << w_g;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack   <= '0;
      r_write <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
      r_ptr   <= '0;
      r_mask  <= '0;
    end else begin
      r_ack   <= w_grant ? w_onehot : '0;
      r_mask  <= w_grant ? w_onehot : '0;
      r_write <= w_grant;
      if (w_grant) begin
        r_data <= {w_g, event_data[w_g*EVENT_W +: EVENT_W]};
        r_ptr  <= w_next_ptr;
        if (r_count != {CNT_W{1'b1}}) r_count <= r_count + 1'b1;
      end
    end
  end

  assign event_ack   = r_ack;
  assign fifo_write  = r_write;
  assign fifo_data   = r_data;
  assign event_count = r_count;
  assign busy        = (|event_valid) | r_write;

endmodule

// File: tb/tb_channel_event_arbiter.sv
// Directed bench for channel_event_arbiter, plus a CNT_W=4 copy
// on the same stimulus for counter saturation.
module tb_channel_event_arbiter;
  import larpix_arb_pkg::*;

  localparam int N  = 64;
  localparam int EW = 36;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          arb_enable = 1'b0;
  logic          fifo_full = 1'b0;
  logic [N-1:0]  event_valid = '0;
  logic [N*EW-1:0] event_data;

  logic [N-1:0]  ack;
  logic          wr;
  logic [41:0]   data;
  logic          busy;
  logic [15:0]   cnt;

  logic [N-1:0]  ack4;
  logic          wr4;
  logic [41:0]   data4;
  logic          busy4;
  logic [3:0]    cnt4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  channel_event_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .arb_enable  (arb_enable),
    .event_valid (event_valid),
    .event_data  (event_data),
    .event_ack   (ack),
    .fifo_full   (fifo_full),
    .fifo_write  (wr),
    .fifo_data   (data),
    .busy        (busy),
    .event_count (cnt)
  );

  channel_event_arbiter #(.CNT_W(4)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .arb_enable  (arb_enable),
    .event_valid (event_valid),
    .event_data  (event_data),
    .event_ack   (ack4),
    .fifo_full   (fifo_full),
    .fifo_write  (wr4),
    .fifo_data   (data4),
    .busy        (busy4),
    .event_count (cnt4)
  );

  function automatic logic [EW-1:0] pay(input int k);
    logic [EW-1:0] p;
    p = 36'h9_0000_0000 ^ (36'(k) * 36'h0_0123_4567);
    return p;
  endfunction

  function automatic logic [41:0] expw(input int k);
    fifo_word_t w;
    w.chan_id = 6'(k);
    w.payload = pay(k);
    return w;
  endfunction

  function automatic logic [63:0] oh(input int k);
    logic [63:0] v;
    v = 64'd1 << k;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic drop_acked;
    event_valid = event_valid & ~ack;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int seq [5];
    int nw;
    int exp_ch;

    for (int k = 0; k < N; k++) event_data[k*EW +: EW] = pay(k);

    // Reset state
    reset = 1'b1;
    arb_enable = 1'b1;
    tick;
    tick;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_wr", 64'(wr), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    // Single request on ch5
    event_valid[5] = 1'b1;
    #1;
    chk("t1_busy_comb", 64'(busy), 64'd1);
    tick;
    chk("t1_ack", 64'(ack), oh(5));
    chk("t1_wr", 64'(wr), 64'd1);
    chk("t1_data", 64'(data), 64'(expw(5)));
    chk("t1_cnt", 64'(cnt), 64'd1);
    drop_acked;
    tick;
    chk("t1_wr_off", 64'(wr), 64'd0);
    chk("t1_busy_off", 64'(busy), 64'd0);

    // ch3,10,63 held: order 3,10,63,3,10 with pointer wrap
    rst_pulse;
    event_valid = '0;
    event_valid[3]  = 1'b1;
    event_valid[10] = 1'b1;
    event_valid[63] = 1'b1;
    seq = '{3, 10, 63, 3, 10};
    for (int j = 0; j < 5; j++) begin
      tick;
      chk("t2_data", 64'(data), 64'(expw(seq[j])));
      chk("t2_ack", 64'(ack), oh(seq[j]));
    end
    chk("t2_cnt", 64'(cnt), 64'd5);
    event_valid = '0;
    tick;
    tick;
    chk("t2_idle", 64'(wr), 64'd0);

    // ch7 alone held 6 cycles: every other cycle
    event_valid[7] = 1'b1;
    nw = 0;
    for (int j = 0; j < 6; j++) begin
      tick;
      chk("t3_alt", 64'(wr), (j % 2 == 0) ? 64'd1 : 64'd0);
      if (wr) nw++;
    end
    chk("t3_nwrites", 64'(nw), 64'd3);
    chk("t3_cnt", 64'(cnt), 64'd8);
    event_valid = '0;
    tick;

    // All valid, fifo_full two cycles mid-burst
    rst_pulse;
    event_valid = '1;
    exp_ch = 0;
    for (int i = 0; i < 30; i++) begin
      fifo_full = (i == 10 || i == 11);
      tick;
      if (i == 10 || i == 11) begin
        chk("t4_full_nowr", 64'(wr), 64'd0);
      end else begin
        chk("t4_data", 64'(data), 64'(expw(exp_ch)));
        chk("t4_ack", 64'(ack), oh(exp_ch));
        exp_ch++;
      end
      drop_acked;
    end
    fifo_full = 1'b0;
    chk("t4_cnt", 64'(cnt), 64'd28);

    // arb_enable low: committed write stays, then nothing
    arb_enable = 1'b0;
    #1;
    chk("t4_inflight", 64'(wr), 64'd1);
    tick;
    chk("t4_dis_wr0", 64'(wr), 64'd0);
    tick;
    chk("t4_dis_wr1", 64'(wr), 64'd0);
    chk("t4_dis_cnt", 64'(cnt), 64'd28);
    arb_enable = 1'b1;
    tick;
    chk("t4_resume", 64'(data), 64'(expw(28)));

    // Reset right after a grant: clears asynchronously
    reset = 1'b1;
    #1;
    chk("t5_wr", 64'(wr), 64'd0);
    chk("t5_ack", 64'(ack), 64'd0);
    chk("t5_cnt", 64'(cnt), 64'd0);
    chk("t5_data", 64'(data), 64'd0);
    #1;
    reset = 1'b0;
    tick;
    chk("t5_rearb", 64'(data), 64'(expw(28)));
    chk("t5_cnt1", 64'(cnt), 64'd1);

    // Saturation on the CNT_W=4 copy
    rst_pulse;
    event_valid = '1;
    for (int i = 0; i < 20; i++) begin
      tick;
      drop_acked;
      if (i == 14) begin
        chk("t6_cnt4_15", 64'(cnt4), 64'd15);
        chk("t6_cnt_15", 64'(cnt), 64'd15);
      end
    end
    chk("t6_last_data", 64'(data), 64'(expw(19)));
    chk("t6_cnt_20", 64'(cnt), 64'd20);
    chk("t6_cnt4_sat", 64'(cnt4), 64'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
